// File: rtl/isa_pkg.sv
// isa_pkg: instruction-set definitions shared by the encoder and the decoder.
// Holds the mnemonic enum, opcode/sub-op codes, register-bank offsets and
// the encoder's error codes.
package isa_pkg;

    typedef enum logic [3:0] {
        AND, SLT, OR, JR, LW, SW, ADD, ADDI, TR, BEQ, SUB, SRL, SRA, SLL, HALT
    } mnem_t;

    localparam int WORD_W = 9;

    // Major opcodes, word bits [8:6]
    localparam logic [2:0] OPC_ALU  = 3'b000;
    localparam logic [2:0] OPC_MEM  = 3'b001;
    localparam logic [2:0] OPC_ADD  = 3'b010;
    localparam logic [2:0] OPC_ADDI = 3'b011;
    localparam logic [2:0] OPC_TR   = 3'b100;
    localparam logic [2:0] OPC_BEQ  = 3'b101;
    localparam logic [2:0] OPC_SUB  = 3'b110;
    localparam logic [2:0] OPC_SHF  = 3'b111;

    // Sub-operation codes, word bits [1:0]
    localparam logic [1:0] SUB_AND  = 2'b00;
    localparam logic [1:0] SUB_SLT  = 2'b01;
    localparam logic [1:0] SUB_OR   = 2'b10;
    localparam logic [1:0] SUB_JR   = 2'b11;
    localparam logic [1:0] SUB_LW   = 2'b00;
    localparam logic [1:0] SUB_SW   = 2'b01;
    localparam logic [1:0] SUB_BEQ  = 2'b00;
    localparam logic [1:0] SUB_SRL  = 2'b00;
    localparam logic [1:0] SUB_SRA  = 2'b01;
    localparam logic [1:0] SUB_SLL  = 2'b10;
    localparam logic [1:0] SUB_HALT = 2'b11;

    // Register-bank offsets subtracted before packing a field
    localparam logic [3:0] RS_BANK_OFF = 4'd4;
    localparam logic [3:0] RD_BANK_OFF = 4'd8;

    // Encoder error codes
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_FIELD = 2'b01;
    localparam logic [1:0] ERR_OVF   = 2'b10;

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational packer, mnemonic + register fields -> 9-bit word.
// Configuration macro ENC_FIELD_CHECK_EN: when defined, field_ok reports
// whether every register field lies in its encodable range; when undefined,
// fields are simply truncated and field_ok is tied high.
module instr_pack
    import isa_pkg::*;
(
    input  mnem_t              mnem,
    input  logic [3:0]         rs,
    input  logic [3:0]         rt,
    input  logic [3:0]         rd,
    input  logic [1:0]         imm,
    output logic [WORD_W-1:0]  word,
    output logic               field_ok
);

    logic [1:0] rs_f;
    logic [1:0] rt_f;
    logic [1:0] rt_hi_f;
    logic [1:0] rd_f;
    logic [1:0] rd_hi_f;
    logic [2:0] tr_rd_f;
    logic [2:0] tr_rs_f;

    // Bank-offset subtraction followed by truncation to the field width
    always_comb begin
        rs_f    = 2'(rs - RS_BANK_OFF);
        rt_f    = 2'(rt);
        rt_hi_f = 2'(rt - RD_BANK_OFF);
        rd_f    = 2'(rd);
        rd_hi_f = 2'(rd - RD_BANK_OFF);
        tr_rd_f = 3'(rd);
        tr_rs_f = 3'(rs - RS_BANK_OFF);
    end

    // Word assembly per mnemonic
    always_comb begin
        word = '0;
        case (mnem)
            AND:     word = {OPC_ALU,  rs_f, rt_f,    SUB_AND};
            SLT:     word = {OPC_ALU,  rs_f, rt_hi_f, SUB_SLT};
            OR:      word = {OPC_ALU,  rs_f, rt_f,    SUB_OR};
            JR:      word = {OPC_ALU,  rs_f, 2'b00,   SUB_JR};
            LW:      word = {OPC_MEM,  rs_f, rd_f,    SUB_LW};
            SW:      word = {OPC_MEM,  rs_f, rt_f,    SUB_SW};
            ADD:     word = {OPC_ADD,  rs_f, rt_f,    rd_hi_f};
            ADDI:    word = {OPC_ADDI, rs_f, rd_f,    imm};
            TR:      word = {OPC_TR,   tr_rd_f, tr_rs_f};
            BEQ:     word = {OPC_BEQ,  rs_f, rt_f,    SUB_BEQ};
            SUB:     word = {OPC_SUB,  rs_f, rt_f,    rd_hi_f};
            SRL:     word = {OPC_SHF,  rs_f, rt_f,    SUB_SRL};
            SRA:     word = {OPC_SHF,  rs_f, rt_f,    SUB_SRA};
            SLL:     word = {OPC_SHF,  rs_f, rt_f,    SUB_SLL};
            HALT:    word = {OPC_SHF,  4'b0000,       SUB_HALT};
            default: word = '0;
        endcase
    end

`ifdef ENC_FIELD_CHECK_EN
    logic rs_lo_ok;
    logic rs_tr_ok;
    logic rt_lo_ok;
    logic rt_hi_ok;
    logic rd_lo_ok;
    logic rd_hi_ok;
    logic rd_tr_ok;

    // Range check of each register field against the bank it encodes
    always_comb begin
        rs_lo_ok = (rs >= 4'd4) && (rs <= 4'd7);
        rs_tr_ok = (rs >= 4'd4) && (rs <= 4'd11);
        rt_lo_ok = (rt <= 4'd3);
        rt_hi_ok = (rt >= 4'd8) && (rt <= 4'd11);
        rd_lo_ok = (rd <= 4'd3);
        rd_hi_ok = (rd >= 4'd8) && (rd <= 4'd11);
        rd_tr_ok = (rd <= 4'd7);
        field_ok = 1'b1;
        case (mnem)
            AND, OR, SW, BEQ,
            SRL, SRA, SLL: field_ok = rs_lo_ok && rt_lo_ok;
            SLT:           field_ok = rs_lo_ok && rt_hi_ok;
            JR:            field_ok = rs_lo_ok;
            LW, ADDI:      field_ok = rs_lo_ok && rd_lo_ok;
            ADD, SUB:      field_ok = rs_lo_ok && rt_lo_ok && rd_hi_ok;
            TR:            field_ok = rd_tr_ok && rs_tr_ok;
            HALT:          field_ok = 1'b1;
            default:       field_ok = 1'b1;
        endcase
    end
`else
    assign field_ok = 1'b1;
`endif

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: load-session FSM that encodes a stream of instruction fields
// and writes the packed words into instruction memory, one per transfer.
// Configuration macro ENC_FIELD_CHECK_EN (in instr_pack) enables rejection
// of out-of-range register fields with err_code 01.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               in_valid,
    output logic               in_ready,
    input  mnem_t              in_mnem,
    input  logic [3:0]         in_rs,
    input  logic [3:0]         in_rt,
    input  logic [3:0]         in_rd,
    input  logic [1:0]         in_imm,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [ADDR_W:0]    instr_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERR} state_t;

    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W:0]     count_q,    count_d;
    logic                we_q,       we_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [INSTR_W-1:0]  wdata_q,    wdata_d;
    logic [1:0]          err_code_q, err_code_d;

    logic [WORD_W-1:0]   word;
    logic                field_ok;
    logic                xfer;

    instr_pack u_pack (
        .mnem     (in_mnem),
        .rs       (in_rs),
        .rt       (in_rt),
        .rd       (in_rd),
        .imm      (in_imm),
        .word     (word),
        .field_ok (field_ok)
    );

    // Next-state, pointer, counter and write-port computation
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_code_d = err_code_q;
        xfer       = in_valid && (state_q == ST_LOAD);

        if (start) begin
            // A new session overrides anything happening this cycle
            state_d    = ST_LOAD;
            wr_ptr_d   = base_addr;
            count_d    = '0;
            err_code_d = ERR_NONE;
        end else if (xfer) begin
            if (!field_ok) begin
                state_d    = ST_ERR;
                err_code_d = ERR_FIELD;
            end else begin
                we_d    = 1'b1;
                addr_d  = wr_ptr_q;
                wdata_d = word;
                count_d = count_q + CNT_ONE;
                // Pointer never wraps; the last address ends the session
                if (wr_ptr_q != PTR_MAX) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                end
                if (in_mnem == HALT) begin
                    state_d = ST_DONE;
                end else if (wr_ptr_q == PTR_MAX) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_OVF;
                end
            end
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_code_q <= err_code_d;
        end
    end

    assign in_ready    = (state_q == ST_LOAD);
    assign busy        = (state_q == ST_LOAD);
    assign done        = (state_q == ST_DONE);
    assign err         = (state_q == ST_ERR);
    assign err_code    = err_code_q;
    assign instr_count = count_q;
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;

endmodule
